// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam int unsigned PKG_DATA_WIDTH   = 32;
  localparam logic [PKG_DATA_WIDTH-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    FAULT = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/pc_next.sv
// Next-PC datapath: sequential successor, branch target, select and alignment flag.
module pc_next
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic                  pcsrc,
  output logic [DATA_WIDTH-1:0] next_pc_c,
  output logic [DATA_WIDTH-1:0] next_pc_plus4_c,
  output logic                  misaligned_c
);

  logic [DATA_WIDTH-1:0] seq_pc;
  logic [DATA_WIDTH-1:0] branch_pc;

  // All additions wrap modulo 2^DATA_WIDTH
  always_comb begin
    seq_pc           = pc + DATA_WIDTH'(INSTR_BYTES);
    branch_pc        = pc + imm;
    next_pc_c        = pcsrc ? branch_pc : seq_pc;
    next_pc_plus4_c  = next_pc_c + DATA_WIDTH'(INSTR_BYTES);
    misaligned_c     = |next_pc_c[1:0];
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem read at a time and
// hands the returned word to decode. Optional misaligned-target trap is
// enabled with the FETCH_MISALIGN_CHECK_EN macro.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  input  logic                  imem_ready,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_valid,
  input  logic                  instr_ack,
  input  logic                  PCsrc,
  input  logic [DATA_WIDTH-1:0] ImmExt,
  output logic [DATA_WIDTH-1:0] PC,
  output logic [DATA_WIDTH-1:0] PCPlus4,
  output logic                  fetch_fault
);

  localparam logic [DATA_WIDTH-1:0] RESET_PC_PLUS4 = RESET_PC + DATA_WIDTH'(INSTR_BYTES);

  fetch_state_t          state, state_nxt;
  logic [DATA_WIDTH-1:0] pc_q, pc_nxt;
  logic [DATA_WIDTH-1:0] pc4_q, pc4_nxt;
  logic [DATA_WIDTH-1:0] instr_q, instr_nxt;
  logic                  req_q, req_nxt;
  logic                  valid_q, valid_nxt;
  logic                  fault_q, fault_nxt;

  logic [DATA_WIDTH-1:0] next_pc;
  logic [DATA_WIDTH-1:0] next_pc_plus4;
  logic                  misaligned;

  pc_next #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_pc_next (
    .pc              (pc_q),
    .imm             (ImmExt),
    .pcsrc           (PCsrc),
    .next_pc_c       (next_pc),
    .next_pc_plus4_c (next_pc_plus4),
    .misaligned_c    (misaligned)
  );

`ifndef FETCH_MISALIGN_CHECK_EN
  // Alignment flag has no consumer when the trap is compiled out
  logic unused_misaligned;
  assign unused_misaligned = misaligned;
`endif

  // Next-state and next-register values; outputs are registered from the next state
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    pc4_nxt   = pc4_q;
    instr_nxt = instr_q;

    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (imem_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          instr_nxt = imem_rdata;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (instr_ack) begin
          pc_nxt    = next_pc;
          pc4_nxt   = next_pc_plus4;
          state_nxt = REQ;
`ifdef FETCH_MISALIGN_CHECK_EN
          if (misaligned) state_nxt = FAULT;
`endif
        end
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      FAULT: state_nxt = FAULT;
`endif
      default: state_nxt = IDLE;
    endcase

    req_nxt   = (state_nxt == REQ);
    valid_nxt = (state_nxt == HOLD);
`ifdef FETCH_MISALIGN_CHECK_EN
    fault_nxt = (state_nxt == FAULT);
`else
    fault_nxt = 1'b0;
`endif
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pc_q    <= RESET_PC;
      pc4_q   <= RESET_PC_PLUS4;
      instr_q <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc_q    <= pc_nxt;
      pc4_q   <= pc4_nxt;
      instr_q <= instr_nxt;
      req_q   <= req_nxt;
      valid_q <= valid_nxt;
      fault_q <= fault_nxt;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign PC          = pc_q;
  assign PCPlus4     = pc4_q;
  assign fetch_fault = fault_q;

endmodule
